// File: rtl/store_buffer_align_pkg.sv
// Shared store-side definitions: store widths, byte-enable masks and the
// layout of one store-buffer entry.
package store_buffer_align_pkg;

  // Store width encoding as produced by the decoder (2'b11 is reserved)
  typedef enum logic [1:0] {
    ST_B    = 2'b00,
    ST_H    = 2'b01,
    ST_W    = 2'b10,
    ST_RSVD = 2'b11
  } st_type_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_H0   = 4'b0011;
  localparam logic [3:0] BE_H1   = 4'b1100;
  localparam logic [3:0] BE_W    = 4'b1111;

  // One pending write: word address, lane-replicated data and byte mask
  typedef struct packed {
    logic [29:0] word;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

  // Rebuild the byte address of a stored word
  function automatic logic [31:0] word_to_addr(input logic [29:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/store_buffer_align_align.sv
// Store alignment: turns a store width, the low address bits and rs2 into a
// byte-enable mask, lane-replicated write data and a misalignment flag.
module store_align
  import store_buffer_align_pkg::*;
(
  input  logic [1:0]  st_type,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned
);

  // Decode the mask and replicate the significant bytes into every lane
  always_comb begin
    be         = BE_NONE;
    wdata      = data;
    misaligned = 1'b0;
    case (st_type)
      ST_B: begin
        be    = BE_B0 << offset;
        wdata = {4{data[7:0]}};
      end
      ST_H: begin
        be         = offset[1] ? BE_H1 : BE_H0;
        wdata      = {2{data[15:0]}};
        misaligned = offset[0];
      end
      default: begin
        be         = BE_W;
        wdata      = data;
        misaligned = (offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/store_buffer_align.sv
// MEM-stage store buffer: aligns SB/SH/SW requests, queues them in a small
// FIFO, drains them to Data Memory in order and flags load/store word hazards.
module store_buffer_align
  import store_buffer_align_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic        st_valid,
  input  logic [1:0]  st_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        misalign_exc,
  input  logic        ld_check_valid,
  input  logic [31:0] ld_check_addr,
  output logic        ld_hazard,
  output logic        mem_wvalid,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wbe,
  input  logic        mem_wready,
  output logic        buf_empty
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic [3:0]  al_be;
  logic [31:0] al_data;
  logic        al_misaligned;
  logic        full;
  logic        empty;
  logic        accept;
  logic        enq;
  logic        deq;
  logic        ld_offset_unused;

  // Only the word part of a load address takes part in the hazard compare
  assign ld_offset_unused = ^ld_check_addr[1:0];

  store_align u_align (
    .st_type    (st_type),
    .offset     (st_addr[1:0]),
    .data       (st_data),
    .be         (al_be),
    .wdata      (al_data),
    .misaligned (al_misaligned)
  );

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign st_ready = !full;
  assign accept   = st_valid && st_ready;
  assign enq      = accept && !al_misaligned;
  assign deq      = !empty && mem_wready;

  // The write port always presents the head slot; storage is cleared on reset
  assign mem_wvalid = !empty;
  assign buf_empty  = empty;
  assign mem_waddr  = word_to_addr(entries[rd_ptr].word);
  assign mem_wdata  = entries[rd_ptr].data;
  assign mem_wbe    = entries[rd_ptr].be;

  // Queue state: enqueue at the tail, retire at the head, pulse misalign
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      valid        <= '0;
      misalign_exc <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      misalign_exc <= accept && al_misaligned;
      if (deq) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      if (enq) begin
        entries[wr_ptr] <= '{word: st_addr[31:2], data: al_data, be: al_be};
        valid[wr_ptr]   <= 1'b1;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Word-address match against every pending entry, head included
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].word == ld_check_addr[31:2])) begin
        ld_hazard = 1'b1;
      end
    end
    ld_hazard = ld_hazard && ld_check_valid;
  end

  // The reserved width code should never reach the buffer
  assert property (@(posedge CPU_CLK) disable iff (CPU_RST)
                   st_valid |-> (st_type != ST_RSVD));

endmodule
